// File: rtl/rom_read_arbiter_if.sv
// Client-request, ROM-port and read-return bundle for rom_read_arbiter.
// The slave modport is the arbiter's view; master is the clients/ROM side.
interface rom_read_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 16
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic [AW-1:0] len0;
    logic          gnt0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [AW-1:0] len1;
    logic          gnt1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid0;
    logic          rd_valid1;
    logic          rd_last;
    logic          busy;

    modport slave (
        input  req0, addr0, len0, req1, addr1, len1, rom_data,
        output gnt0, gnt1, rom_addr, rd_data, rd_valid0, rd_valid1, rd_last, busy
    );

    modport master (
        output req0, addr0, len0, req1, addr1, len1, rom_data,
        input  gnt0, gnt1, rom_addr, rd_data, rd_valid0, rd_valid1, rd_last, busy
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-client burst arbiter in front of a 1-cycle registered-read ROM.
// Bursts are granted only from IDLE, issued one address per cycle in ISSUE,
// and the final word returns during the single DRAIN cycle.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration; otherwise
// client 0 has fixed priority on simultaneous requests.
module rom_read_arbiter #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rom_read_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] cur_addr_reg;
    logic [AW-1:0] remaining_reg;
    logic          owner_reg;
    logic          issue_reg;
    logic          last_reg;
    logic          grant_any;
    logic          winner;

`ifdef ROM_ARB_RR_EN
    logic          rr_reg;

    // Round-robin pointer toggles on every grant, including lone-requester grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_reg <= 1'b0;
        end else if (grant_any) begin
            rr_reg <= ~rr_reg;
        end
    end

    // Contention goes to the pointer; a lone requester always wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            winner = rr_reg;
        end else begin
            winner = ~bus.req0;
        end
    end
`else
    // Fixed priority: client 0 wins whenever it is requesting.
    always_comb begin
        winner = ~bus.req0;
    end
`endif

    // Next-state and grant decision; grants happen only in IDLE.
    always_comb begin
        state_next = state_reg;
        grant_any  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_any  = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (remaining_reg == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, burst counters and the one-stage return pipeline.
    // cur_addr stops advancing on the last issue so rom_addr holds the final
    // address through DRAIN and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            owner_reg     <= 1'b0;
            issue_reg     <= 1'b0;
            last_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            issue_reg <= (state_reg == ISSUE);
            last_reg  <= (state_reg == ISSUE) && (remaining_reg == '0);
            if (grant_any) begin
                cur_addr_reg  <= winner ? bus.addr1 : bus.addr0;
                remaining_reg <= winner ? bus.len1 : bus.len0;
                owner_reg     <= winner;
            end else if ((state_reg == ISSUE) && (remaining_reg != '0)) begin
                cur_addr_reg  <= cur_addr_reg + 1'b1;
                remaining_reg <= remaining_reg - 1'b1;
            end
        end
    end

    // Grant pulses are forced low while reset is asserted so every output
    // sits at its reset value during reset, even with a request pending.
    assign bus.gnt0      = rst_n & grant_any & ~winner;
    assign bus.gnt1      = rst_n & grant_any & winner;
    assign bus.rom_addr  = cur_addr_reg;
    assign bus.rd_data   = bus.rom_data;
    assign bus.rd_valid0 = issue_reg & ~owner_reg;
    assign bus.rd_valid1 = issue_reg & owner_reg;
    assign bus.rd_last   = last_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural 128x16 ROM whose
// word at address a is {8'hC3, 1'b0, a}.
module tb_rom_read_arbiter;
    localparam int AW = 7;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rom_read_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rom_read_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {8'hC3, 1'b0, a};
    endfunction

    // Registered-read ROM model.
    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0  = 1'b0;
        bus.addr0 = '0;
        bus.len0  = '0;
        bus.req1  = 1'b0;
        bus.addr1 = '0;
        bus.len1  = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Follows one granted burst from the first ISSUE cycle to the IDLE cycle
    // after DRAIN. Cycle c issues addr+c; its word returns in cycle c+1.
    task automatic run_burst(input int client, input logic [AW-1:0] addr,
                             input logic [AW-1:0] len);
        int n;
        logic [AW-1:0] ea;
        logic [AW-1:0] da;
        logic ev0, ev1, el;
        n = int'(len) + 1;
        for (int c = 0; c <= n; c++) begin
            ea  = (c < n) ? addr + AW'(c) : addr + len;
            ev0 = (c >= 1) && (client == 0);
            ev1 = (c >= 1) && (client == 1);
            el  = (c == n);
            checks++;
            if (bus.rom_addr !== ea) begin
                errors++;
                $display("FAIL rom_addr c=%0d: got %0d expected %0d", c, bus.rom_addr, ea);
            end
            checks++;
            if ({bus.rd_valid0, bus.rd_valid1, bus.rd_last} !== {ev0, ev1, el}) begin
                errors++;
                $display("FAIL valid/last c=%0d: got %b%b%b expected %b%b%b", c,
                         bus.rd_valid0, bus.rd_valid1, bus.rd_last, ev0, ev1, el);
            end
            if (c >= 1) begin
                da = addr + AW'(c - 1);
                checks++;
                if (bus.rd_data !== rom_word(da)) begin
                    errors++;
                    $display("FAIL rd_data c=%0d: got %h expected %h", c, bus.rd_data, rom_word(da));
                end
            end
            checks++;
            if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b100) begin
                errors++;
                $display("FAIL busy/gnt c=%0d: got %b%b%b expected 100", c,
                         bus.busy, bus.gnt0, bus.gnt1);
            end
            step();
        end
        checks++;
        if ({bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last} !== 4'b0000) begin
            errors++;
            $display("FAIL idle after burst: got %b%b%b%b expected 0000",
                     bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last);
        end
        $display("burst client %0d addr %0d len %0d complete", client, addr, len);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rd_valid0, bus.rd_valid1, bus.rd_last, bus.busy} !== 6'b0
            || bus.rom_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset state: got flags %b%b%b%b%b%b rom_addr %0d expected 0",
                     bus.gnt0, bus.gnt1, bus.rd_valid0, bus.rd_valid1, bus.rd_last, bus.busy,
                     bus.rom_addr);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last} !== 4'b0) begin
            errors++;
            $display("FAIL idle after reset: got %b%b%b%b expected 0000",
                     bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last);
        end
        $display("reset check done");
    endtask

    task automatic test_single_burst();
        bus.req0 = 1'b1; bus.addr0 = 7'd10; bus.len0 = 7'd3;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL single gnt: got %b%b%b expected 100", bus.gnt0, bus.gnt1, bus.busy);
        end
        step();
        bus.req0 = 1'b0;
        run_burst(0, 7'd10, 7'd3);
    endtask

    task automatic test_wrap();
        bus.req1 = 1'b1; bus.addr1 = 7'd126; bus.len1 = 7'd3;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL wrap gnt: got %b%b expected 01", bus.gnt0, bus.gnt1);
        end
        step();
        bus.req1 = 1'b0;
        run_burst(1, 7'd126, 7'd3);
    endtask

    task automatic test_full_length();
        bus.req0 = 1'b1; bus.addr0 = 7'd0; bus.len0 = 7'd127;
        #1;
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL full gnt0: got %b expected 1", bus.gnt0);
        end
        step();
        bus.req0 = 1'b0;
        run_burst(0, 7'd0, 7'd127);
    endtask

    task automatic test_req_glitch();
        bus.req1 = 1'b1; bus.addr1 = 7'd50; bus.len1 = 7'd2;
        #1;
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL glitch gnt1: got %b expected 1", bus.gnt1);
        end
        step();
        bus.req1 = 1'b0; bus.addr1 = 7'd99; bus.len1 = 7'd7;
        run_burst(1, 7'd50, 7'd2);
    endtask

    task automatic test_reset_mid_burst();
        bus.req0 = 1'b1; bus.addr0 = 7'd60; bus.len0 = 7'd7;
        step();
        bus.req0 = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.rd_valid0 !== 1'b1 || bus.rd_data !== rom_word(7'd62)) begin
            errors++;
            $display("FAIL third word: got v=%b data %h expected v=1 data %h",
                     bus.rd_valid0, bus.rd_data, rom_word(7'd62));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rd_valid0, bus.rd_valid1, bus.rd_last, bus.busy} !== 6'b0
            || bus.rom_addr !== 7'd0) begin
            errors++;
            $display("FAIL async reset: got flags %b%b%b%b%b%b rom_addr %0d expected 0",
                     bus.gnt0, bus.gnt1, bus.rd_valid0, bus.rd_valid1, bus.rd_last, bus.busy,
                     bus.rom_addr);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if ({bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last} !== 4'b0) begin
                errors++;
                $display("FAIL post-reset k=%0d: got %b%b%b%b expected 0000", k,
                         bus.busy, bus.rd_valid0, bus.rd_valid1, bus.rd_last);
            end
        end
        $display("reset mid-burst check done");
    endtask

    task automatic test_simultaneous();
        int exp_client;
        apply_reset();
        bus.req0 = 1'b1; bus.addr0 = 7'd20; bus.len0 = 7'd1;
        bus.req1 = 1'b1; bus.addr1 = 7'd40; bus.len1 = 7'd1;
        #1;
        for (int g = 0; g < 4; g++) begin
`ifdef ROM_ARB_RR_EN
            exp_client = g % 2;
`else
            exp_client = 0;
`endif
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {exp_client == 0, exp_client == 1}) begin
                errors++;
                $display("FAIL simultaneous grant %0d: got %b%b expected client %0d",
                         g, bus.gnt0, bus.gnt1, exp_client);
            end
            step();
            run_burst(exp_client, (exp_client == 0) ? 7'd20 : 7'd40, 7'd1);
        end
        bus.req0 = 1'b0;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL lone client 1 grant: got %b%b expected 01", bus.gnt0, bus.gnt1);
        end
        step();
        bus.req1 = 1'b0;
        run_burst(1, 7'd40, 7'd1);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_burst();
        test_wrap();
        test_full_length();
        test_req_glitch();
        test_reset_mid_burst();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
